// File: rtl/rssi_cmp_pkg.sv
// Shared types and constants for the RSSI comparator interface and SAR search engine.
package rssi_cmp_pkg;

  localparam int unsigned RSSI_WIDTH = 6;

  localparam int unsigned CMP_LT = 0;
  localparam int unsigned CMP_EQ = 1;
  localparam int unsigned CMP_GT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2
  } sar_state_t;

  // Exactly one of lt/eq/gt must be set for a trustworthy comparator answer.
  function automatic logic is_one_hot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/sar_settle_timer.sv
// Down-counter that holds each SAR trial for SETTLE_CYCLES+1 cycles and flags the sample edge.
module sar_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_run,
  output logic o_strobe_c
);
  localparam int unsigned CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES);

  logic [CW-1:0] r_cnt;

  assign o_strobe_c = i_run && (r_cnt == '0);

  // Reload on a new conversion and after every sample so each bit gets the same window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load || o_strobe_c) begin
      r_cnt <= RELOAD;
    end else if (i_run) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/rssi_sar_search.sv
// Successive-approximation RSSI search driving the 6-bit magnitude comparator.
// Optional: define SAR_EARLY_EXIT_EN to end a conversion on the first equal result.
module rssi_sar_search
  import rssi_cmp_pkg::*;
#(
  parameter int unsigned WIDTH         = RSSI_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cmp_result,
  output logic [WIDTH-1:0] cmp_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rssi_est,
  output logic             err
);
  localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sar_state_t       r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_cmp_val;
  logic [WIDTH-1:0] r_rssi_est;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic             w_load;
  logic             w_run;
  logic             w_strobe_c;
  logic             w_valid;
  logic             w_last;
  logic [WIDTH-1:0] w_bit;
  logic [WIDTH-1:0] w_decided;
  logic [WIDTH-1:0] w_next;

  assign w_load = (r_state == IDLE) && start;
  assign w_run  = (r_state == TRIAL);

  sar_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_run      (w_run),
    .o_strobe_c (w_strobe_c)
  );

  // Trial bit k is cleared on gt, kept on lt/eq; the next lower bit is then set.
  assign w_valid   = is_one_hot3(cmp_result);
  assign w_bit     = WIDTH'(1) << r_k;
  assign w_decided = cmp_result[CMP_GT] ? (r_cmp_val & ~w_bit) : r_cmp_val;
  assign w_next    = w_decided | (w_bit >> 1);

`ifdef SAR_EARLY_EXIT_EN
  assign w_last = (r_k == '0) || cmp_result[CMP_EQ];
`else
  assign w_last = (r_k == '0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_cmp_val  <= '0;
      r_rssi_est <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= TRIAL;
            r_k       <= KW'(WIDTH - 1);
            r_cmp_val <= WIDTH'(1) << (WIDTH - 1);
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
          end
        end
        TRIAL: begin
          if (w_strobe_c) begin
            if (!w_valid || w_last) begin
              r_state    <= DONE;
              r_k        <= '0;
              r_cmp_val  <= '0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_err      <= !w_valid;
              r_rssi_est <= w_valid ? w_decided : '0;
            end else begin
              r_k       <= r_k - KW'(1);
              r_cmp_val <= w_next;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign cmp_val  = r_cmp_val;
  assign busy     = r_busy;
  assign done     = r_done;
  assign rssi_est = r_rssi_est;
  assign err      = r_err;

endmodule
